// File: rtl/dispatch_resource_ctrl_if.sv
// Dispatch admission bundle: decode-side lane info, release counts,
// squash, and the hazard/count results returned to dispatch.
interface dispatch_resource_ctrl_if #(
   parameter int WIDTH    = 2,
   parameter int ROB_SIZE = 32,
   parameter int RS_SIZE  = 16,
   parameter int LSQ_SIZE = 8
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(ROB_SIZE + 1);
   localparam int SW = $clog2(RS_SIZE + 1);
   localparam int LW = $clog2(LSQ_SIZE + 1);

   logic [WIDTH-1:0] valid_inst;
   logic [WIDTH-1:0] needs_lsq;
   logic [WIDTH-1:0] is_halt;
   logic [CW-1:0]    rob_retire_cnt;
   logic [CW-1:0]    rs_release_cnt;
   logic [CW-1:0]    lsq_release_cnt;
   logic             squash;
   logic [WIDTH-1:0] ROB_hazard;
   logic [WIDTH-1:0] RS_hazard;
   logic [CW-1:0]    dispatch_cnt;
   logic [RW-1:0]    rob_free;
   logic [SW-1:0]    rs_free;
   logic [LW-1:0]    lsq_free;
   logic             halted;

   modport master (
      output valid_inst, needs_lsq, is_halt,
      output rob_retire_cnt, rs_release_cnt, lsq_release_cnt, squash,
      input  ROB_hazard, RS_hazard, dispatch_cnt,
      input  rob_free, rs_free, lsq_free, halted
   );

   modport slave (
      input  valid_inst, needs_lsq, is_halt,
      input  rob_retire_cnt, rs_release_cnt, lsq_release_cnt, squash,
      output ROB_hazard, RS_hazard, dispatch_cnt,
      output rob_free, rs_free, lsq_free, halted
   );
endinterface

// File: rtl/dispatch_resource_ctrl.sv
// Superscalar dispatch admission controller: tracks ROB/RS/LSQ free
// entries, derives per-lane hazards for in-order prefix dispatch, and
// sequences squash recovery and halt.
module dispatch_resource_ctrl #(
   parameter int WIDTH    = 2,
   parameter int ROB_SIZE = 32,
   parameter int RS_SIZE  = 16,
   parameter int LSQ_SIZE = 8
) (
   input logic                   clock,
   input logic                   reset,
   dispatch_resource_ctrl_if.slave dif
);
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int RW  = $clog2(ROB_SIZE + 1);
   localparam int SW  = $clog2(RS_SIZE + 1);
   localparam int LW  = $clog2(LSQ_SIZE + 1);
   localparam int M1  = (RW > SW) ? RW : SW;
   localparam int M2  = (LW > CW) ? LW : CW;
   localparam int MW  = (M1 > M2) ? M1 : M2;

   typedef enum logic [1:0] {ST_RUN, ST_RECOVER, ST_HALTED} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [RW-1:0]    r_rob_free;
   logic [SW-1:0]    r_rs_free;
   logic [LW-1:0]    r_lsq_free;

   logic [CW-1:0]    w_nv;
   logic [CW-1:0]    w_nl;
   logic [CW-1:0]    w_cnt;
   logic             w_pre;
   logic             w_halt_disp;
   logic             w_run;
   logic             w_halted;
   logic             w_sq_eff;
   logic [WIDTH-1:0] w_rob_h;
   logic [WIDTH-1:0] w_rs_h;
   logic [WIDTH-1:0] w_disp;
   logic [RW:0]      w_rob_sum;
   logic [SW:0]      w_rs_sum;
   logic [LW:0]      w_lsq_sum;
   logic             w_rob_ovf;
   logic             w_rs_ovf;
   logic             w_lsq_ovf;
   logic [RW-1:0]    w_rob_nxt;
   logic [SW-1:0]    w_rs_nxt;
   logic [LW-1:0]    w_lsq_nxt;

   // Squash only acts while not halted.
   assign w_sq_eff = dif.squash & (r_state != ST_HALTED);

   // Per-lane hazards and dispatch decisions, walking lanes in program order.
   always_comb begin
      w_nv        = '0;
      w_nl        = '0;
      w_cnt       = '0;
      w_pre       = 1'b0;
      w_halt_disp = 1'b0;
      w_rob_h     = '0;
      w_rs_h      = '0;
      w_disp      = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         w_nv = w_nv + CW'(dif.valid_inst[j]);
         w_nl = w_nl + CW'(dif.valid_inst[j] & dif.needs_lsq[j]);
         w_rob_h[j] = (MW'(w_nv) > MW'(r_rob_free)) | w_pre | ~w_run | dif.squash;
         w_rs_h[j]  = (MW'(w_nv) > MW'(r_rs_free))
                    | (dif.needs_lsq[j] & (MW'(w_nl) > MW'(r_lsq_free)));
         w_disp[j]  = dif.valid_inst[j] & ~w_rob_h[j] & ~w_rs_h[j];
         // A stalled lane or a dispatched halt ends the dispatchable prefix.
         w_pre       = w_pre | (dif.valid_inst[j] & ~w_disp[j]) | (w_disp[j] & dif.is_halt[j]);
         w_halt_disp = w_halt_disp | (w_disp[j] & dif.is_halt[j]);
         w_cnt       = w_cnt + CW'(w_disp[j]);
      end
   end

   // Next free counts; sums carry one extra bit so overflow is detectable.
   always_comb begin
      w_rob_sum = (RW+1)'(r_rob_free) - (RW+1)'(w_cnt) + (RW+1)'(dif.rob_retire_cnt);
      w_rs_sum  = (SW+1)'(r_rs_free)  - (SW+1)'(w_cnt) + (SW+1)'(dif.rs_release_cnt);
      w_lsq_sum = (LW+1)'(r_lsq_free) - (LW+1)'(w_nl & {CW{1'b0}})
                - (LW+1)'($countones(w_disp & dif.needs_lsq))
                + (LW+1)'(dif.lsq_release_cnt);
      w_rob_ovf = w_rob_sum > (RW+1)'(ROB_SIZE);
      w_rs_ovf  = w_rs_sum  > (SW+1)'(RS_SIZE);
      w_lsq_ovf = w_lsq_sum > (LW+1)'(LSQ_SIZE);
      w_rob_nxt = w_rob_ovf ? RW'(ROB_SIZE) : w_rob_sum[RW-1:0];
      w_rs_nxt  = w_rs_ovf  ? SW'(RS_SIZE)  : w_rs_sum[SW-1:0];
      w_lsq_nxt = w_lsq_ovf ? LW'(LSQ_SIZE) : w_lsq_sum[LW-1:0];
   end

   // Free-count registers: reset/squash reload to full, otherwise account.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rob_free <= RW'(ROB_SIZE);
         r_rs_free  <= SW'(RS_SIZE);
         r_lsq_free <= LW'(LSQ_SIZE);
      end else if (w_sq_eff) begin
         r_rob_free <= RW'(ROB_SIZE);
         r_rs_free  <= SW'(RS_SIZE);
         r_lsq_free <= LW'(LSQ_SIZE);
      end else begin
         r_rob_free <= w_rob_nxt;
         r_rs_free  <= w_rs_nxt;
         r_lsq_free <= w_lsq_nxt;
      end
   end

   // Releasing more entries than are outstanding is a protocol error.
   always_ff @(posedge clock) begin
      if (!reset && !w_sq_eff) begin
         assert (!w_rob_ovf && !w_rs_ovf && !w_lsq_ovf);
      end
   end

   // Control state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and state-decoded flags.
   always_comb begin
      w_state_nxt = r_state;
      w_run       = 1'b0;
      w_halted    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_run = 1'b1;
            if (dif.squash) begin
               w_state_nxt = ST_RECOVER;
            end else if (w_halt_disp) begin
               w_state_nxt = ST_HALTED;
            end
         end
         ST_RECOVER: begin
            w_state_nxt = dif.squash ? ST_RECOVER : ST_RUN;
         end
         ST_HALTED: begin
            w_halted = 1'b1;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   assign dif.ROB_hazard   = w_rob_h;
   assign dif.RS_hazard    = w_rs_h;
   assign dif.dispatch_cnt = w_cnt;
   assign dif.rob_free     = r_rob_free;
   assign dif.rs_free      = r_rs_free;
   assign dif.lsq_free     = r_lsq_free;
   assign dif.halted       = w_halted;
endmodule

// File: tb/tb_dispatch_resource_ctrl.sv
// Directed and random checks of dispatch_resource_ctrl against a
// lane-by-lane reference model of the admission rules.
module tb_dispatch_resource_ctrl;
   localparam int WIDTH = 2;
   localparam int ROBS  = 32;
   localparam int RSS   = 16;
   localparam int LSQS  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dispatch_resource_ctrl_if #(.WIDTH(WIDTH), .ROB_SIZE(ROBS), .RS_SIZE(RSS), .LSQ_SIZE(LSQS)) dif ();

   dispatch_resource_ctrl #(.WIDTH(WIDTH), .ROB_SIZE(ROBS), .RS_SIZE(RSS), .LSQ_SIZE(LSQS)) dut (
      .clock (clk),
      .reset (rst),
      .dif   (dif)
   );

   int errs   = 0;
   int checks = 0;

   // reference model state
   int m_rob, m_rs, m_lsq;
   bit m_halted, m_recover;
   // model expectations for current cycle
   logic [1:0] e_robh, e_rsh;
   int e_cnt, e_lsq_used;
   bit e_halt;
   // DUT observations captured in the last step
   logic [1:0] o_robh, o_rsh;
   int o_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_init();
      m_rob = ROBS; m_rs = RSS; m_lsq = LSQS;
      m_halted = 0; m_recover = 0;
   endfunction

   // Apply the admission rules lane by lane in program order.
   function automatic void model_eval(input logic [1:0] v, input logic [1:0] l,
                                      input logic [1:0] h, input logic sq);
      int nv = 0, nl = 0;
      bit blocked = 0;
      e_cnt = 0; e_lsq_used = 0; e_halt = 0; e_robh = '0; e_rsh = '0;
      for (int j = 0; j < WIDTH; j++) begin
         bit d;
         if (v[j]) nv++;
         if (v[j] && l[j]) nl++;
         e_robh[j] = (nv > m_rob) || blocked || m_halted || m_recover || sq;
         e_rsh[j]  = (nv > m_rs) || (l[j] && (nl > m_lsq));
         d = v[j] && !e_robh[j] && !e_rsh[j];
         if (v[j] && !d) blocked = 1;
         if (d && h[j]) begin blocked = 1; e_halt = 1; end
         if (d) begin e_cnt++; if (l[j]) e_lsq_used++; end
      end
   endfunction

   task automatic step(input logic [1:0] v, input logic [1:0] l, input logic [1:0] h,
                       input int rr, input int sr, input int lr, input logic sq);
      dif.valid_inst = v; dif.needs_lsq = l; dif.is_halt = h;
      dif.rob_retire_cnt = 2'(rr); dif.rs_release_cnt = 2'(sr);
      dif.lsq_release_cnt = 2'(lr); dif.squash = sq;
      @(negedge clk);
      model_eval(v, l, h, sq);
      check("rob_hazard", 32'(dif.ROB_hazard & v), 32'(e_robh & v));
      check("rs_hazard",  32'(dif.RS_hazard & v),  32'(e_rsh & v));
      check("dispatch_cnt", 32'(dif.dispatch_cnt), 32'(e_cnt));
      check("rob_free", 32'(dif.rob_free), 32'(m_rob));
      check("rs_free",  32'(dif.rs_free),  32'(m_rs));
      check("lsq_free", 32'(dif.lsq_free), 32'(m_lsq));
      check("halted",   32'(dif.halted),   32'(m_halted));
      o_robh = dif.ROB_hazard; o_rsh = dif.RS_hazard; o_cnt = int'(dif.dispatch_cnt);
      @(posedge clk);
      if (sq && !m_halted) begin
         m_rob = ROBS; m_rs = RSS; m_lsq = LSQS; m_recover = 1;
      end else begin
         m_rob = m_rob - e_cnt + rr;
         m_rs  = m_rs  - e_cnt + sr;
         m_lsq = m_lsq - e_lsq_used + lr;
         if (m_recover) m_recover = 0;
         else if (e_halt) m_halted = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      dif.valid_inst = '0; dif.needs_lsq = '0; dif.is_halt = '0;
      dif.rob_retire_cnt = '0; dif.rs_release_cnt = '0; dif.lsq_release_cnt = '0;
      dif.squash = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_init();
      check("rst_rob_free", 32'(dif.rob_free), 32'(ROBS));
      check("rst_rs_free",  32'(dif.rs_free),  32'(RSS));
      check("rst_lsq_free", 32'(dif.lsq_free), 32'(LSQS));
      check("rst_halted",   32'(dif.halted),   32'(0));
   endtask

   function automatic int rnd_rel(input int free_now, input int size);
      int room = size - free_now;
      int lim = (room < WIDTH) ? room : WIDTH;
      return $urandom_range(0, lim);
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int halt_age;
      // 1: steady dispatch until RS runs dry
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
         if (i < 8) check("t1_cnt", 32'(o_cnt), 32'(2));
         else begin
            check("t1_cnt_stall", 32'(o_cnt), 32'(0));
            check("t1_rs_hazard", 32'(o_rsh), 32'(2'b11));
         end
      end
      check("t1_rs_zero", 32'(dif.rs_free), 32'(0));

      // 2: rob_free=1, rs_free=5
      do_reset();
      for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 2'b00, 0, 2, 0, 1'b0);
      for (int i = 0; i < 5; i++)  step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      step(2'b01, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      check("t2_rob_pre", 32'(dif.rob_free), 32'(1));
      check("t2_rs_pre",  32'(dif.rs_free),  32'(5));
      step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      check("t2_robh", 32'(o_robh), 32'(2'b10));
      check("t2_cnt",  32'(o_cnt),  32'(1));
      check("t2_rob_after", 32'(dif.rob_free), 32'(0));

      // 4: retire in the same cycle is not usable until the next
      step(2'b11, 2'b00, 2'b00, 2, 0, 0, 1'b0);
      check("t4_cnt0", 32'(o_cnt), 32'(0));
      check("t4_rob2", 32'(dif.rob_free), 32'(2));
      step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      check("t4_cnt2", 32'(o_cnt), 32'(2));

      // 3: LSQ empty blocks a load and everything behind it
      do_reset();
      for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 2'b00, 0, 0, 0, 1'b0);
      check("t3_lsq0", 32'(dif.lsq_free), 32'(0));
      step(2'b11, 2'b01, 2'b00, 0, 0, 0, 1'b0);
      check("t3_rsh0",  32'(o_rsh[0]),  32'(1));
      check("t3_robh1", 32'(o_robh[1]), 32'(1));
      check("t3_cnt",   32'(o_cnt),     32'(0));

      // 5: squash and one recovery cycle
      for (int i = 0; i < 7; i++) step(2'b11, 2'b00, 2'b00, 0, 2, 0, 1'b0);
      check("t5_rob10", 32'(dif.rob_free), 32'(10));
      step(2'b11, 2'b00, 2'b00, 2, 2, 2, 1'b1);
      check("t5_sq_robh", 32'(o_robh), 32'(2'b11));
      check("t5_sq_cnt",  32'(o_cnt),  32'(0));
      check("t5_rob_full", 32'(dif.rob_free), 32'(ROBS));
      check("t5_lsq_full", 32'(dif.lsq_free), 32'(LSQS));
      step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      check("t5_rec_robh", 32'(o_robh), 32'(2'b11));
      step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      check("t5_run_cnt", 32'(o_cnt), 32'(2));

      // 6: halt on lane 0
      step(2'b11, 2'b00, 2'b01, 0, 0, 0, 1'b0);
      check("t6_cnt", 32'(o_cnt), 32'(1));
      check("t6_robh1", 32'(o_robh[1]), 32'(1));
      check("t6_halted", 32'(dif.halted), 32'(1));
      step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b1);
      check("t6_sq_ignored", 32'(o_cnt), 32'(0));
      check("t6_still_halted", 32'(dif.halted), 32'(1));
      step(2'b11, 2'b00, 2'b00, 0, 0, 0, 1'b0);
      check("t6_blocked", 32'(o_cnt), 32'(0));
      do_reset();

      // random traffic against the model
      halt_age = 0;
      for (int i = 0; i < 600; i++) begin
         logic [1:0] v, l, h;
         logic sq;
         if (m_halted) begin
            halt_age++;
            if (halt_age > 3) begin do_reset(); halt_age = 0; end
         end
         v  = 2'($urandom);
         l  = 2'($urandom);
         h  = ($urandom_range(0, 30) == 0) ? 2'($urandom) : 2'b00;
         sq = ($urandom_range(0, 15) == 0);
         step(v, l, h, rnd_rel(m_rob, ROBS), rnd_rel(m_rs, RSS), rnd_rel(m_lsq, LSQS), sq);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
